// File: rtl/dcache_dm.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | dcache_dm : direct-mapped write-through, no-write-allocate D-cache   |
// | Optional hit/miss counters under DCACHE_STATS_EN.  Rev 1.0           |
// +----------------------------------------------------------------------+
module dcache_dm #(
   parameter int WIDTH = 32,
   parameter int SETS  = 256
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             cpu_req,
   input  logic             cpu_we,
   input  logic [3:0]       cpu_be,
   input  logic [WIDTH-1:0] cpu_addr,
   input  logic [WIDTH-1:0] cpu_wdata,
   output logic [WIDTH-1:0] cpu_rdata,
   output logic             stall,
   output logic             mem_req,
   output logic             mem_we,
   output logic [WIDTH-1:0] mem_addr,
   output logic [3:0]       mem_be,
   output logic [WIDTH-1:0] mem_wdata,
   input  logic             mem_ack,
   input  logic [WIDTH-1:0] mem_rdata
`ifdef DCACHE_STATS_EN
   ,
   output logic [31:0]      hit_count,
   output logic [31:0]      miss_count
`endif
);

   localparam int IW = $clog2(SETS);
   localparam int TW = WIDTH - IW - 2;
   localparam logic [WIDTH-1:0] c_wordMask = {{(WIDTH-2){1'b1}}, 2'b00};

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      RD_MISS = 2'd1,
      WR_THRU = 2'd2,
      RESP    = 2'd3
   } state_t;

   state_t r_state, w_nextState;

   logic [SETS-1:0]  r_valid;
   logic [TW-1:0]    r_tagStore  [SETS];
   logic [WIDTH-1:0] r_dataStore [SETS];
   logic [WIDTH-1:0] r_resp;

   logic             r_memReq;
   logic             r_memWe;
   logic [WIDTH-1:0] r_memAddr;
   logic [3:0]       r_memBe;
   logic [WIDTH-1:0] r_memWdata;

   logic [IW-1:0]    w_index;
   logic [TW-1:0]    w_tag;
   logic             w_hit;
   logic             w_isLoad;
   logic             w_isStore;
   logic             w_stall;
   logic [WIDTH-1:0] w_rdata;
   logic [WIDTH-1:0] w_merged;

   assign w_index   = cpu_addr[IW+1:2];
   assign w_tag     = cpu_addr[WIDTH-1:IW+2];
   assign w_hit     = cpu_req & r_valid[w_index] & (r_tagStore[w_index] == w_tag);
   assign w_isLoad  = cpu_req & ~cpu_we;
   assign w_isStore = cpu_req & cpu_we & (cpu_be != 4'b0000);

   always_comb begin
      w_nextState = r_state;
      w_stall     = 1'b0;
      w_rdata     = '0;
      case (r_state)
         IDLE: begin
            if (w_isLoad) begin
               if (w_hit) begin
                  w_rdata = r_dataStore[w_index];
               end else begin
                  w_stall     = 1'b1;
                  w_nextState = RD_MISS;
               end
            end else if (w_isStore) begin
               w_stall     = 1'b1;
               w_nextState = WR_THRU;
            end
         end
         RD_MISS, WR_THRU: begin
            w_stall = 1'b1;
            if (mem_ack) w_nextState = RESP;
         end
         RESP: begin
            if (w_isLoad) w_rdata = r_resp;
            w_nextState = IDLE;
         end
         default: w_nextState = IDLE;
      endcase
   end

   // Byte-lane merge of the held store into the currently stored word
   always_comb begin
      w_merged = r_dataStore[w_index];
      for (int b = 0; b < 4; b++) begin
         if (cpu_be[b]) w_merged[8*b +: 8] = cpu_wdata[8*b +: 8];
      end
   end

   // Core-facing outputs are forced quiet while reset is held
   assign stall     = rst & w_stall;
   assign cpu_rdata = rst ? w_rdata : '0;
   assign mem_req   = r_memReq;
   assign mem_we    = r_memWe;
   assign mem_addr  = r_memAddr;
   assign mem_be    = r_memBe;
   assign mem_wdata = r_memWdata;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state    <= IDLE;
         r_valid    <= '0;
         r_resp     <= '0;
         r_memReq   <= 1'b0;
         r_memWe    <= 1'b0;
         r_memAddr  <= '0;
         r_memBe    <= 4'b0000;
         r_memWdata <= '0;
      end else begin
         r_state <= w_nextState;
         case (r_state)
            IDLE: begin
               if (w_nextState != IDLE) begin
                  r_memReq   <= 1'b1;
                  r_memWe    <= cpu_we;
                  r_memAddr  <= cpu_addr & c_wordMask;
                  r_memBe    <= cpu_we ? cpu_be : 4'b0000;
                  r_memWdata <= cpu_we ? cpu_wdata : '0;
               end
            end
            RD_MISS: begin
               if (mem_ack) begin
                  r_memReq         <= 1'b0;
                  r_valid[w_index] <= 1'b1;
                  r_resp           <= mem_rdata;
               end
            end
            WR_THRU: begin
               if (mem_ack) r_memReq <= 1'b0;
            end
            default: ;
         endcase
      end
   end

   // Tag/data arrays carry no reset; the valid bits qualify them
   always_ff @(posedge clk) begin
      if (r_state == RD_MISS && mem_ack) begin
         r_tagStore[w_index]  <= w_tag;
         r_dataStore[w_index] <= mem_rdata;
      end else if (r_state == WR_THRU && mem_ack && w_hit) begin
         r_dataStore[w_index] <= w_merged;
      end
   end

`ifdef DCACHE_STATS_EN
   logic [31:0] r_hitCount;
   logic [31:0] r_missCount;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_hitCount  <= '0;
         r_missCount <= '0;
      end else if (r_state == IDLE) begin
         if (w_isLoad && w_hit)      r_hitCount  <= r_hitCount + 32'd1;
         if (w_nextState == RD_MISS) r_missCount <= r_missCount + 32'd1;
      end
   end

   assign hit_count  = r_hitCount;
   assign miss_count = r_missCount;
`endif

endmodule
`default_nettype wire

// File: doc/dcache_dm.md
# dcache_dm

Direct-mapped, write-through, no-write-allocate data cache between the MEM stage of the pipelined core and the backing data memory. It serves MEM-stage loads and stores, with one 32-bit word per line. On a load miss or any store it raises `stall` to freeze the pipeline and runs a request/acknowledge transaction to backing memory. Loads that hit return data combinationally in the same cycle with no stall.

## Interface
Parameters:
- `WIDTH`, 32: data and address width.
- `SETS`, 256: number of lines, power of two. Index width is `IW = $clog2(SETS)`.

Ports:
- `clk`  in  1  clock; all state changes on the rising edge.
- `rst`  in  1  asynchronous reset, active-low: asserted at 0.
- `cpu_req`  in  1  MEM-stage access valid.
- `cpu_we`  in  1  1 = store, 0 = load.
- `cpu_be`  in  4  byte enables for stores; ignored for loads.
- `cpu_addr`  in  WIDTH  byte address. Bits [1:0] are ignored; the access is to the word.
- `cpu_wdata`  in  WIDTH  store data, byte lanes aligned to `cpu_be`.
- `cpu_rdata`  out  WIDTH  load data.
- `stall`  out  1  freeze the pipeline; the core holds all `cpu_*` inputs stable while this is 1.
- `mem_req`  out  1  backing-memory request, registered.
- `mem_we`  out  1  request is a write.
- `mem_addr`  out  WIDTH  word-aligned address, bits [1:0] = 0.
- `mem_be`  out  4  write byte enables.
- `mem_wdata`  out  WIDTH  write data.
- `mem_ack`  in  1  one-cycle completion pulse. On a read, `mem_rdata` is valid in the same cycle.
- `mem_rdata`  in  WIDTH  read data.

## Operation
- Address split:
  - index = `cpu_addr[IW+1:2]`.
  - tag = `cpu_addr[WIDTH-1:IW+2]`.
  - Storage per set: valid bit, tag, data word.
- hit = `cpu_req & valid[index] & (tag_store[index] == tag)`.
- States: IDLE, RD_MISS, WR_THRU, RESP.
- IDLE:
  - Load hit: `cpu_rdata` = stored word, `stall` = 0, no state change.
  - Load miss: `stall` = 1 combinationally; next state RD_MISS.
  - Store with `cpu_be` ≠ 0: `stall` = 1; next state WR_THRU.
  - Store with `cpu_be` = 0: no-op, `stall` = 0.
  - No request: `stall` = 0.
- RD_MISS:
  - `mem_req` = 1, `mem_we` = 0, `mem_addr` = word address; `stall` = 1.
  - On `mem_ack`: write data, tag and valid into the set; capture `mem_rdata` in a response register; next state RESP.
- WR_THRU:
  - `mem_req` = 1, `mem_we` = 1, with `mem_be` and `mem_wdata` taken from the held `cpu_*` inputs; `stall` = 1.
  - On `mem_ack`: if the line hits, merge the enabled bytes into the stored word. A missing line is not allocated. Next state RESP.
- RESP:
  - `stall` = 0.
  - For a load, `cpu_rdata` = response register.
  - Next state IDLE unconditionally. The pipeline advances on this edge, so the held request is not re-evaluated.
- `mem_ack` outside RD_MISS/WR_THRU is ignored.
- `cpu_rdata` in states other than a hit or RESP-load: 0.

## Timing
- Reset values: state IDLE, all valid bits 0, response register 0, `mem_req`/`mem_we` 0, `mem_addr`/`mem_be`/`mem_wdata` 0.
- While `rst` = 0, `stall` = 0 and `cpu_rdata` = 0 regardless of inputs.
- Load hit latency: 0 cycles.
- Load miss penalty: `stall` high from the request cycle through the `mem_ack` cycle, plus one cycle, i.e. N + 2 cycles for an ack arriving N cycles after `mem_req` rises.
- `mem_req` rises on the edge after the miss or store is detected. It stays high until the edge on which `mem_ack` is sampled, then falls.
- Reset asserted mid-transaction: `mem_req` drops immediately (asynchronous), the transaction is abandoned, and no line is written.
- A store to the same word as a preceding load is ordered naturally: only one transaction is ever outstanding.

## Configuration
- `DCACHE_STATS_EN` defined:
  - Adds output ports `hit_count` and `miss_count`, 32 bits each, reset to 0.
  - `hit_count` increments once per load hit in IDLE.
  - `miss_count` increments on each IDLE→RD_MISS transition.
  - Both counters wrap at 2^32.
- `DCACHE_STATS_EN` undefined: ports and counters are absent and behaviour is otherwise identical.

## Test plan
- Reset, then load 0x100 with ack after 2 cycles and `mem_rdata` = 0xDEADBEEF → `stall` high for 4 cycles, `cpu_rdata` = 0xDEADBEEF in RESP; an immediate reload of 0x100 → hit, `stall` 0, 0xDEADBEEF.
- Store to 0x100 with `cpu_be` = 0011 and data 0x0000CAFE → one write with `mem_be` = 0011; a following load of 0x100 hits and returns 0xDEADCAFE.
- Store to uncached 0x200 → write-through occurs; a subsequent load of 0x200 misses and `mem_req` is issued (no allocate).
- Conflict: load 0x100, then 0x100 + 4·SETS → second load misses and evicts the first; reloading 0x100 misses again.
- Assert `rst` = 0 while in RD_MISS → `mem_req` falls that cycle; after release, load 0x100 misses (valid bits cleared).
- With `DCACHE_STATS_EN`: 3 hits and 2 misses → `hit_count` = 3, `miss_count` = 2.
